// File: rtl/md_unit.sv
// md_unit: HI/LO multiply/divide unit for the E stage.
// mult/multu/div/divu run for a fixed number of busy cycles and then commit to HI/LO.
// mthi/mtlo write in a single cycle.
// Optional feature macro MD_MADD_EN adds madd/maddu/msub/msubu (iOp 6-9).
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iStart,
    input  logic [3:0]  iOp,
    input  logic [31:0] iA,
    input  logic [31:0] iB,
    output logic        oBusy,
    output logic [31:0] oHI,
    output logic [31:0] oLO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
`ifdef MD_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd6;
    localparam logic [3:0] OP_MADDU = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
    localparam logic [3:0] OP_MSUBU = 4'd9;
`endif

    typedef enum logic {IDLE, RUN} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;
    logic [63:0]     pend_q, pend_d;
    logic            pend_wr_q, pend_wr_d;

    logic [63:0]     prod_s, prod_u;
    logic [31:0]     div_b, mag_a, mag_b, uq, ur, sq, sr, uqu, uru;

    // Products and quotients computed from the live operands at the start edge
    always_comb begin
        prod_s = $signed({{32{iA[31]}}, iA}) * $signed({{32{iB[31]}}, iB});
        prod_u = {32'd0, iA} * {32'd0, iB};
        // Divisor forced to 1 on zero so the dividers never see /0; the result is discarded anyway.
        div_b  = (iB == 32'd0) ? 32'd1 : iB;
        // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000 instead of trapping.
        mag_a  = iA[31] ? (~iA + 32'd1) : iA;
        mag_b  = div_b[31] ? (~div_b + 32'd1) : div_b;
        uq     = mag_a / mag_b;
        ur     = mag_a % mag_b;
        sq     = (iA[31] ^ div_b[31]) ? (~uq + 32'd1) : uq;
        sr     = iA[31] ? (~ur + 32'd1) : ur;
        uqu    = iA / div_b;
        uru    = iA % div_b;
    end

    // Next-state logic for the IDLE/RUN sequencer, pending result and HI/LO
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_d    = pend_q;
        pend_wr_d = pend_wr_q;
        case (state_q)
            IDLE: begin
                if (iStart) begin
                    case (iOp)
                        OP_MULT, OP_MULTU: begin
                            pend_d    = (iOp == OP_MULT) ? prod_s : prod_u;
                            pend_wr_d = 1'b1;
                            cnt_d     = CW'(MULT_CYCLES);
                            state_d   = RUN;
                            busy_d    = 1'b1;
                        end
                        OP_DIV, OP_DIVU: begin
                            pend_d    = (iOp == OP_DIV) ? {sr, sq} : {uru, uqu};
                            pend_wr_d = (iB != 32'd0);
                            cnt_d     = CW'(DIV_CYCLES);
                            state_d   = RUN;
                            busy_d    = 1'b1;
                        end
                        OP_MTHI: hi_d = iA;
                        OP_MTLO: lo_d = iA;
`ifdef MD_MADD_EN
                        OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                            if (iOp == OP_MADD)       pend_d = {hi_q, lo_q} + prod_s;
                            else if (iOp == OP_MADDU) pend_d = {hi_q, lo_q} + prod_u;
                            else if (iOp == OP_MSUB)  pend_d = {hi_q, lo_q} - prod_s;
                            else                      pend_d = {hi_q, lo_q} - prod_u;
                            pend_wr_d = 1'b1;
                            cnt_d     = CW'(MULT_CYCLES);
                            state_d   = RUN;
                            busy_d    = 1'b1;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    if (pend_wr_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end
                    pend_wr_d = 1'b0;
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset discards any in-flight operation
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_q    <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_q    <= pend_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign oBusy = busy_q;
    assign oHI   = hi_q;
    assign oLO   = lo_q;

endmodule
